// File: rtl/serial_tx4_pkg.sv
// serial_tx4_pkg -- shared types and constants for the serial_tx4 transmitter.
//   state_t     : frame sequencer states. PARITY exists only when
//                 SERIAL_TX4_PARITY_EN is defined, so the default build
//                 carries a 2-bit encoding with no parity state.
//   DATA_W      : parallel word width.
//   IDLE_LEVEL  : line level between frames.
//   START_BIT   : line level of the start bit.
//   STOP_BIT    : line level of the stop bit.
//   even_parity : even-parity helper, present only with SERIAL_TX4_PARITY_EN.
package serial_tx4_pkg;

  localparam int   DATA_W     = 4;
  localparam logic IDLE_LEVEL = 1'b0;
  localparam logic START_BIT  = 1'b1;
  localparam logic STOP_BIT   = 1'b0;

`ifdef SERIAL_TX4_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  function automatic logic even_parity(input logic [DATA_W-1:0] v);
    return ^v;
  endfunction
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

endpackage

// File: rtl/serial_tx4_bit_timer.sv
// bit_timer -- bit-period divider for serial_tx4.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   clear : hold the count at zero (line idle)
//   tick  : high in the last cycle of each CLKS_PER_BIT-cycle bit period
// The count runs 0..CLKS_PER_BIT-1 and wraps by itself, so consecutive bits
// (and back-to-back frames) need no re-synchronisation.
module bit_timer #(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int               CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  logic [CNT_W-1:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + ONE;
    end
  end

endmodule

// File: rtl/serial_tx4.sv
// serial_tx4 -- 4-bit framed serial transmitter.
//   Frame: start(1), d[0..3] LSB first, [even parity], stop(0); every bit
//   lasts CLKS_PER_BIT cycles. Optional parity bit: define SERIAL_TX4_PARITY_EN.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   d     : parallel word, captured when a load is accepted
//   load  : frame request, accepted only while ready=1
//   ready : a load this cycle is accepted (idle, or last stop cycle)
//   a     : registered serial line, idle 0
//   busy  : frame in progress
//   done  : one-cycle pulse in the last stop cycle
//
// state  | meaning
// IDLE   | line idle, waiting for load
// START  | start bit on the line
// DATA   | data bit bit_idx on the line (shreg[0])
// PARITY | even-parity bit on the line (SERIAL_TX4_PARITY_EN only)
// STOP   | stop bit; last cycle may accept the next frame
module serial_tx4 #(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] d,
  input  logic       load,
  output logic       ready,
  output logic       a,
  output logic       busy,
  output logic       done
);

  import serial_tx4_pkg::*;

  state_t            state, state_d;
  logic [DATA_W-1:0] shreg, shreg_d;
  logic [1:0]        bit_idx, bit_idx_d;
  logic              a_d;
  logic              started;
  logic              tick;
  logic              accept;
`ifdef SERIAL_TX4_PARITY_EN
  logic              par, par_d;
`endif

  bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_bit_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (state == IDLE),
    .tick  (tick)
  );

  // started keeps ready low through reset and for the release edge itself.
  assign ready  = started && ((state == IDLE) || ((state == STOP) && tick));
  assign accept = load && ready;
  assign busy   = (state != IDLE);
  assign done   = (state == STOP) && tick;

  always_comb begin
    state_d   = state;
    shreg_d   = shreg;
    bit_idx_d = bit_idx;
`ifdef SERIAL_TX4_PARITY_EN
    par_d     = par;
`endif
    case (state)
      IDLE: begin
        if (accept) begin
          state_d = START;
          shreg_d = d;
`ifdef SERIAL_TX4_PARITY_EN
          par_d   = even_parity(d);
`endif
        end
      end
      START: begin
        if (tick) state_d = DATA;
      end
      DATA: begin
        if (tick) begin
          bit_idx_d = bit_idx + 2'd1;
          shreg_d   = shreg >> 1;
          if (bit_idx == 2'd3) begin
`ifdef SERIAL_TX4_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef SERIAL_TX4_PARITY_EN
      PARITY: begin
        if (tick) state_d = STOP;
      end
`endif
      STOP: begin
        if (tick) begin
          if (accept) begin
            state_d = START;
            shreg_d = d;
`ifdef SERIAL_TX4_PARITY_EN
            par_d   = even_parity(d);
`endif
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // The line is registered, so it is driven from the next-state view.
    a_d = IDLE_LEVEL;
    case (state_d)
      START:   a_d = START_BIT;
      DATA:    a_d = shreg_d[0];
`ifdef SERIAL_TX4_PARITY_EN
      PARITY:  a_d = par_d;
`endif
      STOP:    a_d = STOP_BIT;
      default: a_d = IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_idx <= '0;
      a       <= IDLE_LEVEL;
      started <= 1'b0;
`ifdef SERIAL_TX4_PARITY_EN
      par     <= 1'b0;
`endif
    end else begin
      state   <= state_d;
      shreg   <= shreg_d;
      bit_idx <= bit_idx_d;
      a       <= a_d;
      started <= 1'b1;
`ifdef SERIAL_TX4_PARITY_EN
      par     <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_serial_tx4.sv
// tb_serial_tx4 -- bench for serial_tx4 with two instances (CLKS_PER_BIT=1
// and 3). A position-in-frame model predicts every output each cycle; the
// directed scenarios also compare captured waveforms with literal vectors.
module tb_serial_tx4;

`ifdef SERIAL_TX4_PARITY_EN
  localparam int NB = 7;
  localparam logic [31:0] A1011 = 32'b0110111;
  localparam logic [31:0] A0001 = 32'h0003803F;
  localparam logic [31:0] AB2B  = 32'b0001011_0010101;
  localparam logic [31:0] A0110 = 32'b0001101;
  localparam logic [31:0] A1001 = 32'b0010011;
`else
  localparam int NB = 6;
  localparam logic [31:0] A1011 = 32'b010111;
  localparam logic [31:0] A0001 = 32'h0000003F;
  localparam logic [31:0] AB2B  = 32'b001011_010101;
  localparam logic [31:0] A0110 = 32'b001101;
  localparam logic [31:0] A1001 = 32'b010011;
`endif
  localparam int L1 = NB;
  localparam int L3 = NB * 3;

  logic       clk;
  logic       rst_n;
  logic       ld [2];
  logic [3:0] dd [2];
  logic       a_o [2];
  logic       busy_o [2];
  logic       done_o [2];
  logic       rdy_o [2];

  int n_tests = 0;
  int n_fail  = 0;

  serial_tx4 #(.CLKS_PER_BIT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .d(dd[0]), .load(ld[0]),
    .ready(rdy_o[0]), .a(a_o[0]), .busy(busy_o[0]), .done(done_o[0])
  );

  serial_tx4 #(.CLKS_PER_BIT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .d(dd[1]), .load(ld[1]),
    .ready(rdy_o[1]), .a(a_o[1]), .busy(busy_o[1]), .done(done_o[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- model: cycle position inside the current frame --------
  int         m_pos [2] = '{-1, -1};
  logic [6:0] m_bits [2];
  logic       m_started = 1'b0;

  function automatic int cpb_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic int len_of(input int i);
    return NB * cpb_of(i);
  endfunction

  // Slot 0 start, slots 1..4 data LSB first, then parity (if any) and stop.
  function automatic logic [6:0] frame_bits(input logic [3:0] v);
    logic [6:0] f;
    f      = '0;
    f[0]   = 1'b1;
    f[4:1] = v;
`ifdef SERIAL_TX4_PARITY_EN
    f[5]   = ^v;
`endif
    return f;
  endfunction

  function automatic logic e_ready(input int i);
    return m_started && (m_pos[i] < 0 || m_pos[i] == len_of(i) - 1);
  endfunction

  function automatic logic e_a(input int i);
    if (m_pos[i] < 0) return 1'b0;
    return m_bits[i][m_pos[i] / cpb_of(i)];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pos[0]  <= -1;
      m_pos[1]  <= -1;
      m_started <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (e_ready(i) && ld[i]) begin
          m_pos[i]  <= 0;
          m_bits[i] <= frame_bits(dd[i]);
        end else if (m_pos[i] >= 0) begin
          m_pos[i] <= (m_pos[i] == len_of(i) - 1) ? -1 : m_pos[i] + 1;
        end
      end
      m_started <= 1'b1;
    end
  end

  task automatic chk(input string name, input int inst,
                     input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d: got %0h expected %0h at %0t", name, inst, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      chk("cyc_a",     i, 32'(a_o[i]),    32'(e_a(i)));
      chk("cyc_busy",  i, 32'(busy_o[i]), 32'(m_pos[i] >= 0));
      chk("cyc_done",  i, 32'(done_o[i]), 32'(m_pos[i] == len_of(i) - 1));
      chk("cyc_ready", i, 32'(rdy_o[i]),  32'(e_ready(i)));
    end
  end

  // ---------------- directed stimulus ----------------
  function automatic logic [31:0] ones(input int n);
    return (32'd1 << n) - 32'd1;
  endfunction

  // Bit k of each vector is the output in cycle k+1 after the load edge.
  task automatic capture(input int inst, input int n, input logic [31:0] ld_sched,
                         input logic [3:0] new_d,
                         output logic [31:0] av, output logic [31:0] bv,
                         output logic [31:0] dv);
    av = '0; bv = '0; dv = '0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      av[k] = a_o[inst];
      bv[k] = busy_o[inst];
      dv[k] = done_o[inst];
      ld[inst] = ld_sched[k];
      if (k == 0) dd[inst] = new_d;
    end
  endtask

  logic [31:0] av, bv, dv;

  initial begin
    rst_n = 1'b0;
    ld[0] = 1'b0; ld[1] = 1'b0;
    dd[0] = 4'h0; dd[1] = 4'h0;
    repeat (3) @(negedge clk);
    chk("rst_a",     0, 32'(a_o[0]),    32'd0);
    chk("rst_busy",  0, 32'(busy_o[0]), 32'd0);
    chk("rst_done",  0, 32'(done_o[0]), 32'd0);
    chk("rst_ready", 0, 32'(rdy_o[0]),  32'd0);
    chk("rst_ready", 1, 32'(rdy_o[1]),  32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_ready", 0, 32'(rdy_o[0]), 32'd1);
    chk("rel_ready", 1, 32'(rdy_o[1]), 32'd1);

    // single frame d=1011, d changed right after acceptance
    dd[0] = 4'b1011; ld[0] = 1'b1;
    capture(0, L1 + 3, 32'd0, 4'h4, av, bv, dv);
    chk("f1011_a",    0, av, A1011);
    chk("f1011_busy", 0, bv, ones(L1));
    chk("f1011_done", 0, dv, 32'd1 << (L1 - 1));

    // three cycles per bit
    dd[1] = 4'b0001; ld[1] = 1'b1;
    capture(1, L3 + 3, 32'd0, 4'hE, av, bv, dv);
    chk("f0001x3_a",    1, av, A0001);
    chk("f0001x3_busy", 1, bv, ones(L3));
    chk("f0001x3_done", 1, dv, 32'd1 << (L3 - 1));

    // load held high: A then 5, back-to-back
    dd[0] = 4'hA; ld[0] = 1'b1;
    capture(0, 2 * L1 + 3, ones(L1), 4'h5, av, bv, dv);
    chk("b2b_a",    0, av, AB2B);
    chk("b2b_busy", 0, bv, ones(2 * L1));
    chk("b2b_done", 0, dv, (32'd1 << (L1 - 1)) | (32'd1 << (2 * L1 - 1)));

    // load pulsed during DATA is ignored
    dd[0] = 4'b0110; ld[0] = 1'b1;
    capture(0, L1 + 4, 32'b10, 4'hF, av, bv, dv);
    chk("ign_a",    0, av, A0110);
    chk("ign_busy", 0, bv, ones(L1));
    chk("ign_done", 0, dv, 32'd1 << (L1 - 1));

    // reset in cycle 3 of a frame
    dd[0] = 4'b1011; ld[0] = 1'b1;
    @(negedge clk); ld[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_abort_a", 0, 32'(a_o[0]), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_a",     0, 32'(a_o[0]),    32'd0);
    chk("abort_busy",  0, 32'(busy_o[0]), 32'd0);
    chk("abort_done",  0, 32'(done_o[0]), 32'd0);
    chk("abort_ready", 0, 32'(rdy_o[0]),  32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel2_ready", 0, 32'(rdy_o[0]), 32'd1);
    dd[0] = 4'b1001; ld[0] = 1'b1;
    capture(0, L1 + 3, 32'd0, 4'h0, av, bv, dv);
    chk("f1001_a",    0, av, A1001);
    chk("f1001_busy", 0, bv, ones(L1));
    chk("f1001_done", 0, dv, 32'd1 << (L1 - 1));

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
